// File: rtl/accumulating_adder_ctrl_pkg.sv
// Shared types and default sizing for the accumulating adder controller.
package acc_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam int NBITS_DEF   = 16;
    localparam int MAX_OPS_DEF = 8;

endpackage

// File: rtl/accumulating_adder_ctrl_cla.sv
// Nbits-wide carry look-ahead adder built from generate/propagate terms.
module CarryLookAheadAdderContinuousAssigment #(
    parameter int Nbits = 16
) (
    input  logic [Nbits-1:0] a_in,
    input  logic [Nbits-1:0] b_in,
    input  logic             Cin,
    output logic [Nbits-1:0] sum,
    output logic             Cout
);

    logic [Nbits-1:0] gen;
    logic [Nbits-1:0] prop;
    logic [Nbits:0]   carry;

    assign gen      = a_in & b_in;
    assign prop     = a_in ^ b_in;
    assign carry[0] = Cin;

    for (genvar i = 0; i < Nbits; i++) begin : g_carry
        assign carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end

    assign sum  = prop ^ carry[Nbits-1:0];
    assign Cout = carry[Nbits];

endmodule

// File: rtl/accumulating_adder_ctrl.sv
// Burst operand accumulator feeding a CLA adder; counts carry-outs per burst.
// Optional saturation (sat output, acc clamps to all-ones) under ACC_SAT_EN.
module accumulating_adder_ctrl
    import acc_adder_pkg::*;
#(
    parameter  int Nbits   = NBITS_DEF,
    parameter  int MAX_OPS = MAX_OPS_DEF,
    localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             op_valid,
    input  logic [Nbits-1:0] op_data,
    output logic             op_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Nbits-1:0] result,
    output logic [CNT_W-1:0] carry_cnt,
`ifdef ACC_SAT_EN
    output logic             sat,
`endif
    output logic             busy
);

    acc_state_t       state_q, state_d;
    logic [Nbits-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             sat_q, sat_d;

    logic [Nbits-1:0] add_sum;
    logic             add_cout;

    CarryLookAheadAdderContinuousAssigment #(
        .Nbits(Nbits)
    ) u_cla (
        .a_in (acc_q),
        .b_in (op_data),
        .Cin  (1'b0),
        .sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_cnt_d = carry_cnt_q;
        remaining_d = remaining_q;
        sat_d       = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    carry_cnt_d = '0;
                    sat_d       = 1'b0;
                    remaining_d = (num_ops > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : num_ops;
                    state_d     = (num_ops == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (op_valid) begin
`ifdef ACC_SAT_EN
                    // once any carry is seen the burst stays pinned at all-ones
                    if (sat_q || add_cout) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = add_sum;
                    end
`else
                    acc_d = add_sum;
`endif
                    carry_cnt_d = carry_cnt_q + CNT_W'(add_cout);
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            carry_cnt_q <= '0;
            remaining_q <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_cnt_q <= carry_cnt_d;
            remaining_q <= remaining_d;
            sat_q       <= sat_d;
        end
    end

    assign op_ready  = (state_q == ACCUM);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM) || (state_q == DONE);
    assign result    = acc_q;
    assign carry_cnt = carry_cnt_q;

`ifdef ACC_SAT_EN
    assign sat = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q ^ sat_d;
`endif

endmodule

// File: tb/tb_accumulating_adder_ctrl.sv
// Directed bench for accumulating_adder_ctrl; expectations are hand-computed.
module tb_accumulating_adder_ctrl;

    localparam int NB    = 16;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] num_ops;
    logic          op_valid;
    logic [NB-1:0] op_data;
    logic          op_ready;
    logic          res_valid;
    logic          res_ready;
    logic [NB-1:0] result;
    logic [CW-1:0] carry_cnt;
    logic          busy;
`ifdef ACC_SAT_EN
    logic          sat;
`endif

    int checks   = 0;
    int failures = 0;

    accumulating_adder_ctrl #(
        .Nbits   (16),
        .MAX_OPS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_ops   (num_ops),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .carry_cnt (carry_cnt),
`ifdef ACC_SAT_EN
        .sat       (sat),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [CW-1:0] n);
        start   = 1'b1;
        num_ops = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic send_op(input logic [NB-1:0] d, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            op_valid = 1'b0;
            tick();
            check("stall_no_result", 32'(res_valid), 32'd0);
        end
        op_valid = 1'b1;
        op_data  = d;
        waited   = 0;
        while (!op_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("op_ready_seen", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("idle_after_release", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_ops = '0;
        op_valid = 1'b0; op_data = '0; res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_op_ready",  32'(op_ready),  32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_carry",     32'(carry_cnt), 32'd0);
`ifdef ACC_SAT_EN
        check("rst_sat",       32'(sat),       32'd0);
`endif

        // 1+2+3 back-to-back
        start_burst(4'd3);
        check("t1_busy", 32'(busy), 32'd1);
        send_op(16'h0001, 0);
        send_op(16'h0002, 0);
        check("t1_not_done_yet", 32'(res_valid), 32'd0);
        send_op(16'h0003, 0);
        check("t1_res_valid", 32'(res_valid), 32'd1);
        check("t1_result",    32'(result),    32'h0006);
        check("t1_carry",     32'(carry_cnt), 32'd0);
        release_result();

        // wrap with one carry
        start_burst(4'd2);
        send_op(16'hFFFF, 0);
        send_op(16'h0002, 0);
        check("t2_res_valid", 32'(res_valid), 32'd1);
`ifdef ACC_SAT_EN
        check("t2_result",    32'(result),    32'hFFFF);
        check("t2_sat",       32'(sat),       32'd1);
`else
        check("t2_result",    32'(result),    32'h0001);
`endif
        check("t2_carry",     32'(carry_cnt), 32'd1);
        release_result();

        // zero-length burst, then start coincident with res_ready
        start_burst(4'd0);
        check("t3_res_valid", 32'(res_valid), 32'd1);
        check("t3_op_ready",  32'(op_ready),  32'd0);
        check("t3_result",    32'(result),    32'd0);
        check("t3_carry",     32'(carry_cnt), 32'd0);
        start     = 1'b1;
        num_ops   = 4'd2;
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        check("t3_start_ignored_done", 32'(busy), 32'd0);
        tick();
        check("t3_still_idle", 32'(busy), 32'd0);

        // gaps of 2 cycles, start pulsed mid-burst, result held for 4 cycles
        start_burst(4'd3);
        send_op(16'h0100, 2);
        start   = 1'b1;
        num_ops = 4'd0;
        send_op(16'h0200, 2);
        start   = 1'b0;
        check("t4_mid_op_ready", 32'(op_ready), 32'd1);
        send_op(16'h0300, 2);
        for (int i = 0; i < 4; i++) begin
            check("t4_hold_valid",  32'(res_valid), 32'd1);
            check("t4_hold_result", 32'(result),    32'h0600);
            tick();
        end
        check("t4_carry", 32'(carry_cnt), 32'd0);
        release_result();

        // reset mid-burst
        start_burst(4'd4);
        send_op(16'h1111, 0);
        send_op(16'h2222, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_op_ready",  32'(op_ready),  32'd0);
        check("t5_res_valid", 32'(res_valid), 32'd0);
        check("t5_busy",      32'(busy),      32'd0);
        check("t5_result",    32'(result),    32'd0);
        check("t5_carry",     32'(carry_cnt), 32'd0);
        start_burst(4'd1);
        send_op(16'h1234, 0);
        check("t5_new_valid",  32'(res_valid), 32'd1);
        check("t5_new_result", 32'(result),    32'h1234);
        release_result();

        // num_ops beyond MAX_OPS clamps to 8
        start_burst(4'd15);
        for (int i = 0; i < 8; i++) begin
            send_op(16'h2000, 0);
        end
        check("t6_op_ready", 32'(op_ready),  32'd0);
        check("t6_valid",    32'(res_valid), 32'd1);
`ifdef ACC_SAT_EN
        check("t6_result",   32'(result),    32'hFFFF);
`else
        check("t6_result",   32'(result),    32'h0000);
`endif
        check("t6_carry",    32'(carry_cnt), 32'd1);
        release_result();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
